score_keeper: RTL

- BCD score accumulator for the Asteroids game. Takes point-award requests from game logic through a valid/ready handshake.
- Adds the award one BCD digit per cycle. Saturates at all nines. Tracks the high score and pulses an extra-life strobe.
- Sits directly upstream of the four-digit seven-segment decoder. Its packed score digits drive that decoder's per-digit a/b/c/d inputs.

---
 rtl/score_keeper_pkg.sv | 30 +++
 rtl/score_keeper_bcd_digit_adder.sv | 24 ++
 rtl/score_keeper.sv | 129 ++++++++++++
 3 files changed

// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the BCD score keeper.
package score_pkg;

  localparam int NUM_DIGITS_DEF = 4;

  typedef enum logic [1:0] {
    AWARD_20   = 2'd0,
    AWARD_50   = 2'd1,
    AWARD_100  = 2'd2,
    AWARD_1000 = 2'd3
  } award_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Award code to packed BCD addend (four digits).
  function automatic logic [15:0] award_to_bcd(input award_e code);
    case (code)
      AWARD_20:   return 16'h0020;
      AWARD_50:   return 16'h0050;
      AWARD_100:  return 16'h0100;
      AWARD_1000: return 16'h1000;
      default:    return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/score_keeper_bcd_digit_adder.sv
// Single BCD digit adder with carry in/out; purely combinational.
module bcd_digit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] sum,
  output logic       co
);

  logic [4:0] w_raw;

  assign w_raw = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

  // Decimal correction: (raw - 10) mod 16 equals raw + 6 on the low nibble.
  always_comb begin
    sum = w_raw[3:0];
    co  = 1'b0;
    if (w_raw > 5'd9) begin
      sum = w_raw[3:0] + 4'd6;
      co  = 1'b1;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Serial BCD score accumulator: one digit per cycle, saturating, with high
// score tracking and an extra-life strobe on thousands-digit change.
module score_keeper
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_score,
  input  logic                    award_valid,
  input  logic [1:0]              award_sel,
  output logic                    award_ready,
  output logic [4*NUM_DIGITS-1:0] score,
  output logic [4*NUM_DIGITS-1:0] hi_score,
  output logic                    busy,
  output logic                    extra_life
);

  localparam int SW = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam int XL = (NUM_DIGITS > 3) ? 3 : NUM_DIGITS - 1;

  state_e          r_state;
  state_e          w_state_next;
  logic [IW-1:0]   r_idx;
  logic [SW-1:0]   r_addend;
  logic [SW-1:0]   r_work;
  logic            r_carry;
  logic [SW-1:0]   r_score;
  logic [SW-1:0]   r_hi;
  logic            r_extra_life;

  logic            w_xfer;
  logic [SW-1:0]   w_award;
  logic [3:0]      w_digit_a;
  logic [3:0]      w_digit_b;
  logic [3:0]      w_digit_sum;
  logic            w_digit_co;
  logic [SW-1:0]   w_result;

  assign w_xfer      = award_valid && award_ready;
  assign w_award     = SW'(award_to_bcd(award_e'(award_sel)));
  assign w_digit_a   = r_work[4*r_idx +: 4];
  assign w_digit_b   = r_addend[4*r_idx +: 4];
  assign w_result    = r_carry ? {NUM_DIGITS{4'h9}} : r_work;

  bcd_digit_adder u_digit_add (
    .a   (w_digit_a),
    .b   (w_digit_b),
    .ci  (r_carry),
    .sum (w_digit_sum),
    .co  (w_digit_co)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next-state logic; clear_score forces IDLE from any state.
  always_comb begin
    w_state_next = r_state;
    if (clear_score) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_xfer) w_state_next = ADD;
        ADD:     if (r_idx == LAST_IDX) w_state_next = COMMIT;
        COMMIT:  w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // FSM outputs: handshake ready and busy flag.
  always_comb begin
    award_ready = (r_state == IDLE) && !clear_score;
    busy        = (r_state != IDLE);
  end

  // Datapath: latch operands, ripple one digit per ADD cycle, commit result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_addend     <= '0;
      r_work       <= '0;
      r_carry      <= 1'b0;
      r_score      <= '0;
      r_hi         <= '0;
      r_extra_life <= 1'b0;
    end else if (clear_score) begin
      r_idx        <= '0;
      r_carry      <= 1'b0;
      r_score      <= '0;
      r_extra_life <= 1'b0;
    end else begin
      r_extra_life <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_addend <= w_award;
            r_work   <= r_score;
            r_carry  <= 1'b0;
            r_idx    <= '0;
          end
        end
        ADD: begin
          r_work[4*r_idx +: 4] <= w_digit_sum;
          r_carry              <= w_digit_co;
          r_idx                <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
        COMMIT: begin
          r_score      <= w_result;
          if (w_result > r_hi) r_hi <= w_result;
          r_extra_life <= (w_result[4*XL +: 4] != r_score[4*XL +: 4]);
        end
        default: ;
      endcase
    end
  end

  assign score      = r_score;
  assign hi_score   = r_hi;
  assign extra_life = r_extra_life;

endmodule
